// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause field layout,
// exception codes and packing helpers for MFC0 reads.
package cp0_ctrl_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 10;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 10;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } status_t;

  typedef struct packed {
    logic       bd;
    logic       ti;
    logic [5:0] ip;
    logic [4:0] exc;
  } cause_t;

  function automatic logic [31:0] pack_status(input status_t s);
    logic [31:0] v;
    v                = 32'h0000_0000;
    v[ST_IM_LO +: 6] = s.im;
    v[ST_EXL]        = s.exl;
    v[ST_IE]         = s.ie;
    return v;
  endfunction

  function automatic logic [31:0] pack_cause(input cause_t c);
    logic [31:0] v;
    v                 = 32'h0000_0000;
    v[CA_BD]          = c.bd;
    v[CA_TI]          = c.ti;
    v[CA_IP_LO +: 6]  = c.ip;
    v[CA_EXC_LO +: 5] = c.exc;
    return v;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled 32-bit Count, Compare register and a
// sticky timer-interrupt flag cleared by a Compare write.
module cp0_timer #(
  parameter int COUNT_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam logic [3:0] PRE_MAX = 4'(COUNT_DIV - 1);

  logic [3:0]  r_pre;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_inc_d;
  logic        r_ti;
  logic        w_wrap;

  assign w_wrap = (r_pre == PRE_MAX);

  // Prescaler and Count; a software load restarts the prescale period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre   <= 4'd0;
      r_count <= 32'h0000_0000;
      r_inc_d <= 1'b0;
    end else if (wr_count) begin
      r_pre   <= 4'd0;
      r_count <= wr_data;
      r_inc_d <= 1'b0;
    end else if (w_wrap) begin
      r_pre   <= 4'd0;
      r_count <= r_count + 32'd1;
      r_inc_d <= 1'b1;
    end else begin
      r_pre   <= r_pre + 4'd1;
      r_count <= r_count;
      r_inc_d <= 1'b0;
    end
  end

  // Compare register and TI; the match is only armed by a real increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_compare <= 32'h0000_0000;
      r_ti      <= 1'b0;
    end else if (wr_compare) begin
      r_compare <= wr_data;
      r_ti      <= 1'b0;
    end else if (r_inc_d && (r_count == r_compare)) begin
      r_compare <= r_compare;
      r_ti      <= 1'b1;
    end else begin
      r_compare <= r_compare;
      r_ti      <= r_ti;
    end
  end

  assign count   = r_count;
  assign compare = r_compare;
  assign ti      = r_ti;

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 control: Status/Cause/EPC/PRId, optional Count/Compare timer,
// masked interrupt request, hardware exception entry and ERET return.
module cp0_ctrl
  import cp0_ctrl_pkg::*;
#(
  parameter int          NUM_HWINT = 6,
  parameter int          PC_W      = 30,
  parameter logic [31:0] PRID_VAL  = 32'h1234_5678,
  parameter int          TIMER_EN  = 1,
  parameter int          COUNT_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           rd_addr,
  output logic [31:0]          rd_data,
  input  logic                 wr_en,
  input  logic [4:0]           wr_addr,
  input  logic [31:0]          wr_data,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic                 exc_req,
  input  logic [4:0]           exc_code,
  input  logic [PC_W-1:0]      exc_pc,
  input  logic                 exc_bd,
  input  logic                 eret,
  output logic                 int_req,
  output logic [PC_W-1:0]      epc,
  output logic                 exl
);

  status_t         r_status;
  logic [5:0]      r_ip;
  logic            r_bd;
  logic [4:0]      r_exc;
  logic [PC_W-1:0] r_epc;

  logic            w_wr_status;
  logic            w_wr_epc;
  logic            w_wr_count;
  logic            w_wr_compare;
  logic            w_capture_pc;
  logic [5:0]      w_hw_pad;
  logic [5:0]      w_ip_eff;
  logic [31:0]     w_count;
  logic [31:0]     w_compare;
  logic            w_ti;
  logic [31:0]     w_epc_rd;
  cause_t          w_cause;

  assign w_wr_status  = wr_en && (wr_addr == CP0_STATUS);
  assign w_wr_epc     = wr_en && (wr_addr == CP0_EPC);
  assign w_wr_count   = wr_en && (wr_addr == CP0_COUNT);
  assign w_wr_compare = wr_en && (wr_addr == CP0_COMPARE);
  // A nested exception (EXL already set) must not clobber the return point
  assign w_capture_pc = exc_req && !r_status.exl;

  generate
    if (TIMER_EN != 0) begin : g_timer
      cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
      ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_count   (w_wr_count),
        .wr_compare (w_wr_compare),
        .wr_data    (wr_data),
        .count      (w_count),
        .compare    (w_compare),
        .ti         (w_ti)
      );
    end else begin : g_no_timer
      assign w_count   = 32'h0000_0000;
      assign w_compare = 32'h0000_0000;
      assign w_ti      = 1'b0;
    end
  endgenerate

  // Widen the external interrupt lines onto the six IP slots
  always_comb begin
    w_hw_pad                = 6'b000000;
    w_hw_pad[NUM_HWINT-1:0] = hw_int;
  end

  // Status: EXL priority is exception > ERET > MTC0; IM/IE only via MTC0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= '0;
    end else begin
      if (w_wr_status) begin
        r_status.im <= wr_data[ST_IM_LO +: 6];
        r_status.ie <= wr_data[ST_IE];
      end else begin
        r_status.im <= r_status.im;
        r_status.ie <= r_status.ie;
      end
      if (exc_req) begin
        r_status.exl <= 1'b1;
      end else if (eret) begin
        r_status.exl <= 1'b0;
      end else if (w_wr_status) begin
        r_status.exl <= wr_data[ST_EXL];
      end else begin
        r_status.exl <= r_status.exl;
      end
    end
  end

  // Cause: IP samples the interrupt lines, BD/ExcCode record exceptions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ip  <= 6'b000000;
      r_bd  <= 1'b0;
      r_exc <= 5'd0;
    end else begin
      r_ip <= w_hw_pad;
      if (exc_req) begin
        r_exc <= exc_code;
      end else begin
        r_exc <= r_exc;
      end
      if (w_capture_pc) begin
        r_bd <= exc_bd;
      end else begin
        r_bd <= r_bd;
      end
    end
  end

  // EPC: delay-slot faults return to the branch, one word earlier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_epc <= '0;
    end else if (w_capture_pc) begin
      r_epc <= exc_bd ? (exc_pc - {{(PC_W-1){1'b0}}, 1'b1}) : exc_pc;
    end else if (w_wr_epc) begin
      r_epc <= wr_data[PC_W+1:2];
    end else begin
      r_epc <= r_epc;
    end
  end

  assign w_ip_eff = r_ip | {w_ti, 5'b00000};
  assign int_req  = r_status.ie & ~r_status.exl & (|(w_ip_eff & r_status.im));
  assign epc      = r_epc;
  assign exl      = r_status.exl;

  // Assemble the architectural Cause and EPC read views
  always_comb begin
    w_cause.bd         = r_bd;
    w_cause.ti         = w_ti;
    w_cause.ip         = w_ip_eff;
    w_cause.exc        = r_exc;
    w_epc_rd           = 32'h0000_0000;
    w_epc_rd[PC_W+1:2] = r_epc;
  end

  // MFC0 read mux; unmapped registers read zero
  always_comb begin
    rd_data = 32'h0000_0000;
    case (rd_addr)
      CP0_COUNT:   rd_data = w_count;
      CP0_COMPARE: rd_data = w_compare;
      CP0_STATUS:  rd_data = pack_status(r_status);
      CP0_CAUSE:   rd_data = pack_cause(w_cause);
      CP0_EPC:     rd_data = w_epc_rd;
      CP0_PRID:    rd_data = PRID_VAL;
      default:     rd_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl: vector table for register/exception behaviour
// plus hand sequences for async reset, read-during-write and the timer.
module tb_cp0_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [5:0]  hw_int;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [29:0] exc_pc;
  logic        exc_bd;
  logic        eret;
  logic        int_req;
  logic [29:0] epc;
  logic        exl;

  int n_err;
  int n_chk;

  cp0_ctrl #(
    .NUM_HWINT (6),
    .PC_W      (30),
    .PRID_VAL  (32'h1234_5678),
    .TIMER_EN  (1),
    .COUNT_DIV (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .hw_int   (hw_int),
    .exc_req  (exc_req),
    .exc_code (exc_code),
    .exc_pc   (exc_pc),
    .exc_bd   (exc_bd),
    .eret     (eret),
    .int_req  (int_req),
    .epc      (epc),
    .exl      (exl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [5:0]  hw;
    logic        exc;
    logic [4:0]  code;
    logic [29:0] pc;
    logic        bd;
    logic        eret;
    logic [4:0]  ra;
    logic [31:0] e_rd;
    logic        e_int;
    logic        e_exl;
    logic [29:0] e_epc;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [5:0] hw, input logic ex, input logic [4:0] cd,
                              input logic [29:0] pc, input logic bd, input logic er,
                              input logic [4:0] ra, input logic [31:0] erd, input logic ei,
                              input logic ee, input logic [29:0] eepc);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.hw = hw; v.exc = ex; v.code = cd;
    v.pc = pc; v.bd = bd; v.eret = er; v.ra = ra; v.e_rd = erd; v.e_int = ei;
    v.e_exl = ee; v.e_epc = eepc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0; hw_int = 6'd0;
    exc_req = 1'b0; exc_code = 5'd0; exc_pc = 30'd0; exc_bd = 1'b0; eret = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    idle();
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_err = 0;
    n_chk = 0;
    //            we    wa     wd             hw     ex    cd     pc            bd    er    ra     e_rd           int   exl   e_epc
    tbl[0]  = mk(1'b0, 5'd0,  32'h0,         6'h00, 1'b0, 5'd0,  30'h0,        1'b0, 1'b0, 5'd15, 32'h1234_5678, 1'b0, 1'b0, 30'h0);
    tbl[1]  = mk(1'b1, 5'd12, 32'h0000_FC01, 6'h00, 1'b0, 5'd0,  30'h0,        1'b0, 1'b0, 5'd12, 32'h0000_FC01, 1'b0, 1'b0, 30'h0);
    tbl[2]  = mk(1'b0, 5'd0,  32'h0,         6'h04, 1'b0, 5'd0,  30'h0,        1'b0, 1'b0, 5'd13, 32'h0000_1000, 1'b1, 1'b0, 30'h0);
    tbl[3]  = mk(1'b1, 5'd12, 32'h0000_FC03, 6'h04, 1'b0, 5'd0,  30'h0,        1'b0, 1'b0, 5'd12, 32'h0000_FC03, 1'b0, 1'b1, 30'h0);
    tbl[4]  = mk(1'b1, 5'd12, 32'h0000_FC01, 6'h00, 1'b0, 5'd0,  30'h0,        1'b0, 1'b0, 5'd12, 32'h0000_FC01, 1'b0, 1'b0, 30'h0);
    tbl[5]  = mk(1'b1, 5'd12, 32'h0000_8001, 6'h20, 1'b0, 5'd0,  30'h0,        1'b0, 1'b0, 5'd13, 32'h0000_8000, 1'b1, 1'b0, 30'h0);
    tbl[6]  = mk(1'b0, 5'd0,  32'h0,         6'h01, 1'b0, 5'd0,  30'h0,        1'b0, 1'b0, 5'd12, 32'h0000_8001, 1'b0, 1'b0, 30'h0);
    tbl[7]  = mk(1'b0, 5'd0,  32'h0,         6'h00, 1'b1, 5'd12, 30'h0C00,     1'b1, 1'b0, 5'd14, 32'h0000_2FFC, 1'b0, 1'b1, 30'h0BFF);
    tbl[8]  = mk(1'b0, 5'd0,  32'h0,         6'h00, 1'b0, 5'd0,  30'h0,        1'b0, 1'b0, 5'd13, 32'h8000_0030, 1'b0, 1'b1, 30'h0BFF);
    tbl[9]  = mk(1'b0, 5'd0,  32'h0,         6'h00, 1'b1, 5'd4,  30'h100,      1'b0, 1'b0, 5'd13, 32'h8000_0010, 1'b0, 1'b1, 30'h0BFF);
    tbl[10] = mk(1'b0, 5'd0,  32'h0,         6'h00, 1'b0, 5'd0,  30'h0,        1'b0, 1'b1, 5'd12, 32'h0000_8001, 1'b0, 1'b0, 30'h0BFF);
    tbl[11] = mk(1'b0, 5'd0,  32'h0,         6'h00, 1'b1, 5'd10, 30'h40,       1'b0, 1'b1, 5'd14, 32'h0000_0100, 1'b0, 1'b1, 30'h40);
    tbl[12] = mk(1'b1, 5'd12, 32'h0000_0000, 6'h00, 1'b1, 5'd0,  30'h3,        1'b1, 1'b1, 5'd12, 32'h0000_0002, 1'b0, 1'b1, 30'h40);
    tbl[13] = mk(1'b1, 5'd12, 32'h0000_FC03, 6'h00, 1'b0, 5'd0,  30'h0,        1'b0, 1'b1, 5'd12, 32'h0000_FC01, 1'b0, 1'b0, 30'h40);
    tbl[14] = mk(1'b1, 5'd14, 32'h1234_5678, 6'h00, 1'b0, 5'd0,  30'h0,        1'b0, 1'b0, 5'd14, 32'h1234_5678, 1'b0, 1'b0, 30'h048D159E);
    tbl[15] = mk(1'b1, 5'd14, 32'h0000_0000, 6'h00, 1'b1, 5'd5,  30'h3FFFFFFF, 1'b0, 1'b0, 5'd14, 32'hFFFF_FFFC, 1'b0, 1'b1, 30'h3FFFFFFF);
    tbl[16] = mk(1'b0, 5'd0,  32'h0,         6'h00, 1'b0, 5'd0,  30'h0,        1'b0, 1'b1, 5'd13, 32'h0000_0014, 1'b0, 1'b0, 30'h3FFFFFFF);
    tbl[17] = mk(1'b0, 5'd0,  32'h0,         6'h00, 1'b1, 5'd0,  30'h0,        1'b1, 1'b0, 5'd13, 32'h8000_0000, 1'b0, 1'b1, 30'h3FFFFFFF);
    tbl[18] = mk(1'b1, 5'd13, 32'hFFFF_FFFF, 6'h00, 1'b0, 5'd0,  30'h0,        1'b0, 1'b0, 5'd3,  32'h0000_0000, 1'b0, 1'b1, 30'h3FFFFFFF);
    tbl[19] = mk(1'b0, 5'd0,  32'h0,         6'h00, 1'b0, 5'd0,  30'h0,        1'b0, 1'b0, 5'd13, 32'h8000_0000, 1'b0, 1'b1, 30'h3FFFFFFF);
    tbl[20] = mk(1'b0, 5'd0,  32'h0,         6'h02, 1'b0, 5'd0,  30'h0,        1'b0, 1'b1, 5'd12, 32'h0000_FC01, 1'b1, 1'b0, 30'h3FFFFFFF);

    rst_n   = 1'b0;
    rd_addr = 5'd15;
    idle();
    #3;
    check("reset int_req", {31'd0, int_req}, 32'd0);
    check("reset exl", {31'd0, exl}, 32'd0);
    check("reset epc", {2'b00, epc}, 32'd0);
    check("reset prid", rd_data, 32'h1234_5678);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      wr_en = tbl[i].wr_en; wr_addr = tbl[i].wr_addr; wr_data = tbl[i].wr_data;
      hw_int = tbl[i].hw; exc_req = tbl[i].exc; exc_code = tbl[i].code;
      exc_pc = tbl[i].pc; exc_bd = tbl[i].bd; eret = tbl[i].eret; rd_addr = tbl[i].ra;
      @(posedge clk);
      #1;
      check($sformatf("row%0d rd_data", i), rd_data, tbl[i].e_rd);
      check($sformatf("row%0d int_req", i), {31'd0, int_req}, {31'd0, tbl[i].e_int});
      check($sformatf("row%0d exl", i), {31'd0, exl}, {31'd0, tbl[i].e_exl});
      check($sformatf("row%0d epc", i), {2'b00, epc}, {2'b00, tbl[i].e_epc});
    end

    // Asynchronous reset in the middle of a cycle with EXL=1, IM=3F
    mtc0(5'd12, 32'h0000_FC03);
    check("pre-reset exl", {31'd0, exl}, 32'd1);
    @(negedge clk);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async int_req", {31'd0, int_req}, 32'd0);
    check("async exl", {31'd0, exl}, 32'd0);
    check("async epc", {2'b00, epc}, 32'd0);
    rd_addr = 5'd15;
    #1;
    check("async prid", rd_data, 32'h1234_5678);
    rd_addr = 5'd12;
    #1;
    check("async status", rd_data, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Timer: COUNT_DIV=2, Compare=5, Count=0 -> TI after the 11th edge
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    rd_addr = 5'd13;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("timer cause k=%0d", k), rd_data, (k >= 11) ? 32'h4000_8000 : 32'h0000_0000);
      check($sformatf("timer int k=%0d", k), {31'd0, int_req}, (k >= 11) ? 32'd1 : 32'd0);
    end
    rd_addr = 5'd9;
    #1;
    check("timer count", rd_data, 32'd6);
    mtc0(5'd11, 32'h0000_0100);
    rd_addr = 5'd13;
    #1;
    check("compare clears ti", rd_data, 32'h0000_0000);

    // Count wrap with Compare=7: reads 0, no TI
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd_addr = 5'd9;
    #1;
    check("count load", rd_data, 32'hFFFF_FFFF);
    mtc0(5'd11, 32'd7);
    step();
    check("count wrap", rd_data, 32'h0000_0000);
    step();
    rd_addr = 5'd13;
    #1;
    check("wrap no ti", rd_data, 32'h0000_0000);

    // Count wrap with Compare=0: TI fires
    mtc0(5'd9, 32'hFFFF_FFFF);
    mtc0(5'd11, 32'd0);
    step();
    step();
    check("wrap ti compare0", rd_data, 32'h4000_8000);
    check("wrap ti int", {31'd0, int_req}, 32'd1);

    // Read during write shows the old value
    @(negedge clk);
    idle();
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_FC01;
    rd_addr = 5'd12;
    #1;
    check("rdw old", rd_data, 32'h0000_8001);
    @(posedge clk);
    #1;
    check("rdw new", rd_data, 32'h0000_FC01);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
